countdown_scheduler: RTL and testbench

Shares one down-counter timing resource among N_REQ requesters. Round-robin arbitration picks a requester, and the block loads that requester's start value. It then counts down on tick pulses and returns a one-cycle done pulse to the granted requester. It sits between the game/control FSMs and the countdown datapath, so each user no longer needs a private counter.

---
 rtl/countdown_scheduler_if.sv | 25 ++
 rtl/countdown_scheduler.sv | 124 ++++++++++++
 tb/tb_countdown_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_scheduler_if.sv
// Handshake bundle between the requesting control FSMs and the shared countdown scheduler.
interface countdown_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic                   tick;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] load_val;
    logic                   abort;
    logic [N_REQ-1:0]       grant;
    logic [CNT_W-1:0]       count;
    logic                   busy;
    logic [N_REQ-1:0]       done;
    logic [1:0]             state;

    modport master (
        output tick, req, load_val, abort,
        input  grant, count, busy, done, state
    );

    modport slave (
        input  tick, req, load_val, abort,
        output grant, count, busy, done, state
    );
endinterface

// File: rtl/countdown_scheduler.sv
// Round-robin shared down-counter: grants one requester, loads its start value, counts ticks, pulses done.
// Define COUNTDOWN_PAUSE_EN to add a pause input that freezes counting in COUNT.
module countdown_scheduler #(
    parameter int N_REQ       = 4,
    parameter int CNT_W       = 4,
    parameter int RR_EN_FIRST = 0
) (
    input  logic clk,
    input  logic reset,
`ifdef COUNTDOWN_PAUSE_EN
    input  logic pause,
`endif
    countdown_scheduler_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] rr_ptr;

    logic             pick_vld;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] nxt_ptr;
    logic [CNT_W-1:0] slice;
    logic             cancel;
    logic             tick_eff;

    // Scan from the highest offset down so the nearest asserted request at/after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int s;
            s = int'(rr_ptr) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (bus.req[s]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(s);
            end
        end
    end

    assign nxt_ptr = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
    assign slice   = bus.load_val[int'(gidx)*CNT_W +: CNT_W];
    assign cancel  = bus.abort | ~bus.req[gidx];

`ifdef COUNTDOWN_PAUSE_EN
    assign tick_eff = bus.tick & ~pause;
`else
    assign tick_eff = bus.tick;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            gidx    <= '0;
            rr_ptr  <= IDX_W'(RR_EN_FIRST);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= LOAD;
                        grant_q <= N_REQ'(1) << pick;
                        gidx    <= pick;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD, COUNT: begin
                    if (cancel) begin
                        // Withdrawal and abort share one exit: no done, pointer still advances.
                        state_q <= IDLE;
                        grant_q <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        rr_ptr  <= nxt_ptr;
                    end else if (state_q == LOAD) begin
                        count_q <= slice;
                        if (slice == '0) begin
                            state_q <= DONE;
                            done_q  <= grant_q;
                        end else begin
                            state_q <= COUNT;
                        end
                    end else if (tick_eff) begin
                        if (count_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= grant_q;
                        end
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    rr_ptr  <= nxt_ptr;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler: single grant, round-robin, zero load, abort/withdrawal, async reset, pause.
module tb_countdown_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
    logic pause = 1'b0;
`endif
    int n_chk = 0;
    int n_err = 0;

    countdown_scheduler_if #(.N_REQ(4), .CNT_W(4)) bus ();

    countdown_scheduler #(.N_REQ(4), .CNT_W(4), .RR_EN_FIRST(0)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef COUNTDOWN_PAUSE_EN
        .pause (pause),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 32'(bus.state), 32'd0);
        chk({tag, ".grant"}, 32'(bus.grant), 32'd0);
        chk({tag, ".count"}, 32'(bus.count), 32'd0);
        chk({tag, ".busy"},  32'(bus.busy),  32'd0);
        chk({tag, ".done"},  32'(bus.done),  32'd0);
    endtask

    initial begin
        bus.req = '0; bus.tick = 1'b0; bus.abort = 1'b0; bus.load_val = '0;
        #2;
        chk_idle("rst");
        #10 reset = 1'b1;
        step();

        // 1: single request, slice1=3, one tick gap to check hold
        bus.load_val = 16'h0030; bus.req = 4'b0010; bus.tick = 1'b1;
        step();
        chk("t1.load.state", 32'(bus.state), 32'd1);
        chk("t1.load.grant", 32'(bus.grant), 32'h2);
        chk("t1.load.busy",  32'(bus.busy),  32'd1);
        step();
        chk("t1.cnt3", 32'(bus.count), 32'd3);
        chk("t1.state", 32'(bus.state), 32'd2);
        bus.tick = 1'b0;
        step();
        chk("t1.hold3", 32'(bus.count), 32'd3);
        bus.tick = 1'b1;
        step(); chk("t1.cnt2", 32'(bus.count), 32'd2);
        step(); chk("t1.cnt1", 32'(bus.count), 32'd1);
        chk("t1.nodone", 32'(bus.done), 32'd0);
        step();
        chk("t1.cnt0", 32'(bus.count), 32'd0);
        chk("t1.done", 32'(bus.done), 32'h2);
        chk("t1.done.grant", 32'(bus.grant), 32'h2);
        chk("t1.done.state", 32'(bus.state), 32'd3);
        bus.req = '0;
        step();
        chk_idle("t1.end");

        // 2: round-robin from a fresh reset
        reset = 1'b0; #2;
        chk_idle("rst2");
        reset = 1'b1;
        step();
        bus.load_val = 16'h1111; bus.req = 4'b1111; bus.tick = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'(1 << (k % 4));
            step();
            chk("t2.grant", 32'(bus.grant), 32'(eg));
            step();
            chk("t2.cnt", 32'(bus.count), 32'd1);
            step();
            chk("t2.done", 32'(bus.done), 32'(eg));
            if (k == 4) bus.req = '0;
            step();
            chk("t2.idle", 32'(bus.grant), 32'd0);
        end
        step();

        // 3: zero load on requester 2, no tick (pointer is at 1 here)
        bus.load_val = 16'h1011; bus.req = 4'b0100; bus.tick = 1'b0;
        step();
        chk("t3.grant", 32'(bus.grant), 32'h4);
        chk("t3.nodone", 32'(bus.done), 32'd0);
        step();
        chk("t3.done", 32'(bus.done), 32'h4);
        chk("t3.cnt", 32'(bus.count), 32'd0);
        bus.req = '0;
        step();
        chk_idle("t3.end");

        // 4a: abort at count 5, tick also high; pointer is 3 so req0 still wins
        bus.load_val = 16'h0009; bus.req = 4'b0001; bus.tick = 1'b1;
        step(); chk("t4a.grant", 32'(bus.grant), 32'h1);
        step(); chk("t4a.cnt9", 32'(bus.count), 32'd9);
        repeat (4) step();
        chk("t4a.cnt5", 32'(bus.count), 32'd5);
        bus.abort = 1'b1;
        step();
        chk_idle("t4a.abort");
        bus.abort = 1'b0; bus.req = 4'b0011;
        step();
        chk("t4a.next", 32'(bus.grant), 32'h2);
        bus.req = '0;   // withdrawal during LOAD
        step();
        chk_idle("t4a.wd_load");

        // 4b: withdrawal at count 5; pointer is 2, so req0 found by wrap
        bus.req = 4'b0001;
        step(); chk("t4b.grant", 32'(bus.grant), 32'h1);
        step();
        repeat (4) step();
        chk("t4b.cnt5", 32'(bus.count), 32'd5);
        bus.req = 4'b0000;
        step();
        chk_idle("t4b.wd");
        bus.req = 4'b0011;
        step();
        chk("t4b.next", 32'(bus.grant), 32'h2);
        bus.req = '0;
        step();

        // 5: async reset at count 4; pointer would otherwise favour index 2
        bus.req = 4'b0001;
        step(); step();
        repeat (5) step();
        chk("t5.cnt4", 32'(bus.count), 32'd4);
        chk("t5.state", 32'(bus.state), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk_idle("t5.async");
        #1 reset = 1'b1;
        bus.req = 4'b1111;
        step();
        chk("t5.first", 32'(bus.grant), 32'h1);
        bus.req = '0;
        step();
        chk_idle("t5.end");

`ifdef COUNTDOWN_PAUSE_EN
        // 6: pause for three cycles at count 2
        bus.load_val = 16'h0004; bus.req = 4'b0001; bus.tick = 1'b1;
        step(); chk("t6.grant", 32'(bus.grant), 32'h1);
        step(); chk("t6.cnt4", 32'(bus.count), 32'd4);
        step(); step();
        chk("t6.cnt2", 32'(bus.count), 32'd2);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6.hold", 32'(bus.count), 32'd2);
        end
        pause = 1'b0;
        step(); chk("t6.cnt1", 32'(bus.count), 32'd1);
        step();
        chk("t6.cnt0", 32'(bus.count), 32'd0);
        chk("t6.done", 32'(bus.done), 32'h1);
        bus.req = '0;
        step();
        chk_idle("t6.end");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
